// File: rtl/trap_csr_unit.sv
// Machine-mode trap/CSR unit: mstatus/mtvec/mscratch/mepc/mcause plus trap/mret redirect FSM.
// Optional feature: define MCYCLE_CSR_EN to add a free-running mcycle counter at 0xB00.
module trap_csr_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_exception,
  input  logic        i_mret,
  input  logic [3:0]  i_causeNum,
  input  logic [31:0] i_pc,
  input  logic        i_csrEn,
  input  logic [1:0]  i_csrOp,
  input  logic [11:0] i_csrAddr,
  input  logic [31:0] i_csrWdata,
  output logic [31:0] o_csrRdata,
  output logic        o_illegalCsr,
  output logic        o_redirect,
  output logic [31:0] o_redirectPc,
  output logic        o_stall
);
  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
`ifdef MCYCLE_CSR_EN
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
`endif

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [31:0] ALIGN4 = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE, TRAP, RET} state_e;

  state_e      state_q, state_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
`ifdef MCYCLE_CSR_EN
  logic [31:0] mcycle_q, mcycle_d;
`endif

  logic [31:0] mstatus_val;
  logic [31:0] csr_rdata;
  logic        csr_impl;
  logic        csr_req;
  logic        csr_wr;
  logic [31:0] csr_wval;
  logic        idle;

  assign mstatus_val = {24'b0, mpie_q, 3'b0, mie_q, 3'b0};
  assign idle        = (state_q == IDLE);

  // Combinational read mux; unimplemented addresses read as zero.
  always_comb begin
    csr_impl  = 1'b1;
    csr_rdata = 32'b0;
    case (i_csrAddr)
      ADDR_MSTATUS:  csr_rdata = mstatus_val;
      ADDR_MTVEC:    csr_rdata = mtvec_q;
      ADDR_MSCRATCH: csr_rdata = mscratch_q;
      ADDR_MEPC:     csr_rdata = mepc_q;
      ADDR_MCAUSE:   csr_rdata = mcause_q;
`ifdef MCYCLE_CSR_EN
      ADDR_MCYCLE:   csr_rdata = mcycle_q;
`endif
      default:       csr_impl  = 1'b0;
    endcase
  end

  assign csr_req = i_csrEn && (i_csrOp != 2'b00);
  // Trap entry and mret take the cycle; a coincident CSR write is dropped.
  assign csr_wr  = csr_req && csr_impl && idle && !i_exception && !i_mret;

  always_comb begin
    case (i_csrOp)
      OP_RW:   csr_wval = i_csrWdata;
      OP_RS:   csr_wval = csr_rdata | i_csrWdata;
      OP_RC:   csr_wval = csr_rdata & ~i_csrWdata;
      default: csr_wval = csr_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
`ifdef MCYCLE_CSR_EN
    mcycle_d   = mcycle_q + 32'd1;
`endif

    case (state_q)
      IDLE: begin
        if (i_exception) begin
          state_d  = TRAP;
          mepc_d   = i_pc & ALIGN4;
          mcause_d = {28'b0, i_causeNum};
          mpie_d   = mie_q;
          mie_d    = 1'b0;
        end else if (i_mret) begin
          state_d = RET;
          mie_d   = mpie_q;
          mpie_d  = 1'b1;
        end else if (csr_wr) begin
          case (i_csrAddr)
            ADDR_MSTATUS: begin
              mie_d  = csr_wval[3];
              mpie_d = csr_wval[7];
            end
            ADDR_MTVEC:    mtvec_d    = csr_wval & ALIGN4;
            ADDR_MSCRATCH: mscratch_d = csr_wval;
            ADDR_MEPC:     mepc_d     = csr_wval & ALIGN4;
            ADDR_MCAUSE:   mcause_d   = csr_wval;
`ifdef MCYCLE_CSR_EN
            ADDR_MCYCLE:   mcycle_d   = csr_wval;
`endif
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect is registered alongside the state it belongs to, so it shows
    // exactly during the single TRAP/RET cycle.
    redirect_d    = (state_d != IDLE);
    redirect_pc_d = 32'b0;
    if (state_d == TRAP)
      redirect_pc_d = mtvec_q & ALIGN4;
    else if (state_d == RET)
      redirect_pc_d = mepc_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mtvec_q       <= 32'b0;
      mscratch_q    <= 32'b0;
      mepc_q        <= 32'b0;
      mcause_q      <= 32'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'b0;
`ifdef MCYCLE_CSR_EN
      mcycle_q      <= 32'b0;
`endif
    end else begin
      state_q       <= state_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
`ifdef MCYCLE_CSR_EN
      mcycle_q      <= mcycle_d;
`endif
    end
  end

  assign o_csrRdata   = csr_rdata;
  assign o_illegalCsr = csr_req && !csr_impl;
  assign o_redirect   = redirect_q;
  assign o_redirectPc = redirect_pc_q;
  assign o_stall      = redirect_q;

endmodule
